// File: rtl/hazard_ctrl_unit_if.sv
`timescale 1ns/1ps
// Interface between the pipeline control path and hazard_ctrl_unit.
// The pipeline side (master) drives decode/memory/branch status.
// The hazard unit (slave) returns freeze, flush, bubble and forwarding controls.
interface hazard_ctrl_unit_if #(
  parameter int DEPTH = 3,
  parameter int CNT_W = 16
);
  localparam int SEL_W = $clog2(DEPTH + 1);

  // Pipeline status into the hazard unit
  logic             start;
  logic             id_valid;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             id_wen;
  logic [4:0]       id_wsel;
  logic             id_is_load;
  logic             dmem_req;
  logic             dhit;
  logic             redirect;

  // Control back to the pipeline latches and bypass muxes
  logic             freeze_if;
  logic             freeze_id;
  logic             freeze_all;
  logic             flush_ifid;
  logic             bubble_idex;
  logic [SEL_W-1:0] fwd_rs_sel;
  logic [SEL_W-1:0] fwd_rt_sel;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output start, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
           id_wen, id_wsel, id_is_load, dmem_req, dhit, redirect,
    input  freeze_if, freeze_id, freeze_all, flush_ifid, bubble_idex,
           fwd_rs_sel, fwd_rt_sel, mem_timeout, stall_cycles
  );

  modport slave (
    input  start, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
           id_wen, id_wsel, id_is_load, dmem_req, dhit, redirect,
    output freeze_if, freeze_id, freeze_all, flush_ifid, bubble_idex,
           fwd_rs_sel, fwd_rt_sel, mem_timeout, stall_cycles
  );
endinterface

// File: rtl/hazard_ctrl_unit.sv
`timescale 1ns/1ps
// Pipeline hazard control.
// A DEPTH-entry scoreboard shadows the destination registers of the
// instructions in EX (entry 0) through WB (entry DEPTH-1). The decode
// instruction is compared against it to detect RAW hazards, choose bypass
// sources, and raise freeze/bubble/flush controls. A small RUN/WAIT machine
// tracks data-memory waits and flags waits that run too long.
module hazard_ctrl_unit #(
  parameter int DEPTH    = 3,   // scoreboard entries, 2..6
  parameter int FWD_EN   = 1,   // 1: bypass network present, stall only on load-use
  parameter int MAX_WAIT = 16,  // memory-wait cycles before mem_timeout
  parameter int CNT_W    = 16   // width of the stall counter
) (
  input  logic              CLK,
  input  logic              nRST,
  hazard_ctrl_unit_if.slave bus
);

  localparam int SEL_W  = $clog2(DEPTH + 1);
  localparam int WCNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // One in-flight writer: does it write, which register, is it a load.
  typedef struct packed {
    logic       valid;
    logic [4:0] wsel;
    logic       is_load;
  } sb_entry_t;

  sb_entry_t         sb_q [DEPTH];
  sb_entry_t         sb_d [DEPTH];

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d, timeout_now;
  logic [CNT_W-1:0]  stall_q, stall_d;

  logic              active;
  logic              memwait;
  logic              redirect_act;
  logic              loaduse_raw;
  logic              loaduse_act;
  logic [DEPTH-1:0]  hit_rs, hit_rt;
  logic [SEL_W-1:0]  fwd_rs, fwd_rt;

  // NOTE: nRST also gates the combinational controls, so every output is 0
  // while reset is held even if the pipeline keeps driving live inputs.
  assign active  = bus.start & nRST;

  // A hit in the same cycle as the request completes the access: no stall.
  assign memwait = active & bus.dmem_req & ~bus.dhit;

  // Compare each decode source with every scoreboard entry; r0 never matches.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      hit_rs[k] = sb_q[k].valid && (sb_q[k].wsel != 5'd0) && bus.id_valid &&
                  bus.id_use_rs && (sb_q[k].wsel == bus.id_rs);
      hit_rt[k] = sb_q[k].valid && (sb_q[k].wsel != 5'd0) && bus.id_valid &&
                  bus.id_use_rt && (sb_q[k].wsel == bus.id_rt);
    end
  end

  // Decide whether decode must wait for a producer.
  always_comb begin
    loaduse_raw = 1'b0;
    if (FWD_EN != 0) begin
      // Only a load still in EX cannot be bypassed in time.
      loaduse_raw = (hit_rs[0] | hit_rt[0]) & sb_q[0].is_load;
    end else begin
      // Without bypassing, any pending writer of a source blocks decode.
      loaduse_raw = |(hit_rs | hit_rt);
    end
  end

  // Priority: memory wait freezes everything, then redirect squashes the
  // decode instruction (so its load-use stall is moot), then load-use.
  assign redirect_act = active & ~memwait & bus.redirect;
  assign loaduse_act  = active & ~memwait & ~bus.redirect & loaduse_raw;

  // Bypass selects: youngest eligible producer wins, 0 means register file.
  always_comb begin
    // NOTE: defaults first, so no path through this block leaves a select
    // unassigned and no latch is inferred.
    fwd_rs = '0;
    fwd_rt = '0;
    // Walk oldest to youngest so the youngest eligible match is kept last.
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (hit_rs[k] && (!sb_q[k].is_load || k != 0)) begin
        fwd_rs = SEL_W'(k + 1);
      end
      if (hit_rt[k] && (!sb_q[k].is_load || k != 0)) begin
        fwd_rt = SEL_W'(k + 1);
      end
    end
    if (FWD_EN == 0 || !active) begin
      fwd_rs = '0;
      fwd_rt = '0;
    end
  end

  // Scoreboard advance: shift toward WB unless frozen or disabled; entry 0
  // takes the decode instruction, or a bubble when decode does not advance.
  always_comb begin
    sb_d = sb_q;
    if (active && !memwait) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        sb_d[k] = sb_q[k - 1];
      end
      if (redirect_act || loaduse_act) begin
        sb_d[0] = '0;
      end else begin
        sb_d[0] = '{valid:   bus.id_valid & bus.id_wen,
                    wsel:    bus.id_wsel,
                    is_load: bus.id_is_load};
      end
    end
  end

  // Scoreboard storage.
  // NOTE: the scoreboard is a handful of flops, not a RAM; every valid bit
  // must clear on reset or a stale writer would raise phantom hazards.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int k = 0; k < DEPTH; k++) begin
        sb_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        sb_q[k] <= sb_d[k];
      end
    end
  end

  // Wait tracker: wait_cnt_d is the number of consecutive wait cycles
  // including the current one, saturating at MAX_WAIT.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_RUN: begin
        wait_cnt_d = '0;
        if (memwait) begin
          state_d    = ST_WAIT;
          wait_cnt_d = WCNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (bus.dhit) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (memwait && (wait_cnt_q < WCNT_W'(MAX_WAIT))) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Timeout flag is visible in the cycle the limit is reached, then sticks.
  assign timeout_now = memwait && (wait_cnt_d >= WCNT_W'(MAX_WAIT));
  assign timeout_d   = timeout_q | timeout_now;

  // Stall counter: frozen or load-use cycles count, redirects do not.
  always_comb begin
    stall_d = stall_q;
    if ((memwait || loaduse_act) && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  // State, counters and sticky flag.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the clock edge.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
      stall_q    <= stall_d;
    end
  end

  assign bus.freeze_all   = memwait;
  assign bus.freeze_if    = loaduse_act;
  assign bus.freeze_id    = loaduse_act;
  assign bus.flush_ifid   = redirect_act;
  assign bus.bubble_idex  = redirect_act | loaduse_act;
  assign bus.fwd_rs_sel   = fwd_rs;
  assign bus.fwd_rt_sel   = fwd_rt;
  assign bus.mem_timeout  = timeout_q | timeout_now;
  assign bus.stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
`timescale 1ns/1ps
// Directed bench for hazard_ctrl_unit. Two instances share one stimulus:
// u_fwd (DEPTH=3, FWD_EN=1, MAX_WAIT=4) and u_nofwd (DEPTH=3, FWD_EN=0).
module tb_hazard_ctrl_unit;

  logic CLK;
  logic nRST;

  hazard_ctrl_unit_if #(.DEPTH(3), .CNT_W(16)) if_a ();
  hazard_ctrl_unit_if #(.DEPTH(3), .CNT_W(16)) if_b ();

  hazard_ctrl_unit #(.DEPTH(3), .FWD_EN(1), .MAX_WAIT(4), .CNT_W(16)) u_fwd (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (if_a)
  );

  hazard_ctrl_unit #(.DEPTH(3), .FWD_EN(0), .MAX_WAIT(16), .CNT_W(16)) u_nofwd (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (if_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        start;
    logic        id_valid;
    logic [4:0]  rs;
    logic        use_rs;
    logic [4:0]  rt;
    logic        use_rt;
    logic        wen;
    logic [4:0]  wsel;
    logic        ld;
    logic        dreq;
    logic        dhit;
    logic        redir;
    logic [4:0]  exp_ctl;   // {freeze_if, freeze_id, freeze_all, flush_ifid, bubble_idex}
    logic [1:0]  exp_rs;
    logic [1:0]  exp_rt;
    logic        exp_tmo;
    logic [15:0] exp_stall;
  } vec_t;

  localparam int NTBL = 24;
  vec_t tbl [NTBL];

  int n_vec = 0;
  int n_err = 0;

  localparam int CTL_LU  = 'b11001;
  localparam int CTL_MW  = 'b00100;
  localparam int CTL_RD  = 'b00011;

  function automatic vec_t mk(input int st, input int v, input int rs, input int urs,
                              input int rt, input int urt, input int wen, input int wsel,
                              input int ld, input int dq, input int dh, input int rd,
                              input int ctl, input int frs, input int frt, input int tmo,
                              input int stl);
    vec_t r;
    r.start     = st[0];
    r.id_valid  = v[0];
    r.rs        = rs[4:0];
    r.use_rs    = urs[0];
    r.rt        = rt[4:0];
    r.use_rt    = urt[0];
    r.wen       = wen[0];
    r.wsel      = wsel[4:0];
    r.ld        = ld[0];
    r.dreq      = dq[0];
    r.dhit      = dh[0];
    r.redir     = rd[0];
    r.exp_ctl   = ctl[4:0];
    r.exp_rs    = frs[1:0];
    r.exp_rt    = frt[1:0];
    r.exp_tmo   = tmo[0];
    r.exp_stall = stl[15:0];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    if_a.start = v.start;  if_b.start = v.start;
    if_a.id_valid = v.id_valid;  if_b.id_valid = v.id_valid;
    if_a.id_rs = v.rs;  if_b.id_rs = v.rs;
    if_a.id_use_rs = v.use_rs;  if_b.id_use_rs = v.use_rs;
    if_a.id_rt = v.rt;  if_b.id_rt = v.rt;
    if_a.id_use_rt = v.use_rt;  if_b.id_use_rt = v.use_rt;
    if_a.id_wen = v.wen;  if_b.id_wen = v.wen;
    if_a.id_wsel = v.wsel;  if_b.id_wsel = v.wsel;
    if_a.id_is_load = v.ld;  if_b.id_is_load = v.ld;
    if_a.dmem_req = v.dreq;  if_b.dmem_req = v.dreq;
    if_a.dhit = v.dhit;  if_b.dhit = v.dhit;
    if_a.redirect = v.redir;  if_b.redirect = v.redir;
  endtask

  // Compare one DUT's outputs (which: 0 = u_fwd, 1 = u_nofwd) with a vector's expectations.
  task automatic check_outs(input string tag, input int which, input vec_t v);
    logic [4:0]  a_ctl;
    logic [1:0]  a_rs, a_rt;
    logic        a_tmo;
    logic [15:0] a_stall;
    if (which == 0) begin
      a_ctl   = {if_a.freeze_if, if_a.freeze_id, if_a.freeze_all, if_a.flush_ifid, if_a.bubble_idex};
      a_rs    = if_a.fwd_rs_sel;
      a_rt    = if_a.fwd_rt_sel;
      a_tmo   = if_a.mem_timeout;
      a_stall = if_a.stall_cycles;
    end else begin
      a_ctl   = {if_b.freeze_if, if_b.freeze_id, if_b.freeze_all, if_b.flush_ifid, if_b.bubble_idex};
      a_rs    = if_b.fwd_rs_sel;
      a_rt    = if_b.fwd_rt_sel;
      a_tmo   = if_b.mem_timeout;
      a_stall = if_b.stall_cycles;
    end
    check($sformatf("%s.ctl", tag),   32'(a_ctl),   32'(v.exp_ctl));
    check($sformatf("%s.fwd_rs", tag), 32'(a_rs),   32'(v.exp_rs));
    check($sformatf("%s.fwd_rt", tag), 32'(a_rt),   32'(v.exp_rt));
    check($sformatf("%s.tmo", tag),   32'(a_tmo),   32'(v.exp_tmo));
    check($sformatf("%s.stall", tag), 32'(a_stall), 32'(v.exp_stall));
  endtask

  // Drive just after a rising edge, compare on the falling edge.
  task automatic apply(input vec_t v, input int which, input string tag);
    @(posedge CLK);
    #1;
    drive(v);
    @(negedge CLK);
    check_outs(tag, which, v);
  endtask

  task automatic reset_dut(input string tag);
    vec_t idle;
    idle = mk(0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0);
    nRST = 1'b0;
    drive(idle);
    repeat (2) @(negedge CLK);
    check_outs({tag, ".a"}, 0, idle);
    check_outs({tag, ".b"}, 1, idle);
    nRST = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t w;
    vec_t z;

    //          st v rs urs rt urt wen wsel ld dq dh rd | ctl     frs frt tmo stall
    tbl[0]  = mk(1,0, 0,0, 0,0, 0, 0, 0, 0,0,0, 0,      0,0,0,0);  // idle
    tbl[1]  = mk(1,1, 1,1, 0,0, 1, 5, 1, 0,0,0, 0,      0,0,0,0);  // lw r5
    tbl[2]  = mk(1,1, 5,1, 2,1, 1, 6, 0, 0,0,0, CTL_LU, 0,0,0,0);  // add r6=r5+r2: load-use
    tbl[3]  = mk(1,1, 5,1, 2,1, 1, 6, 0, 0,0,0, 0,      2,0,0,1);  // retry: bypass from MEM
    tbl[4]  = mk(1,1, 6,1, 5,1, 1, 7, 0, 0,0,0, 0,      1,3,0,1);  // sub r7=r6-r5
    tbl[5]  = mk(1,1, 7,1, 0,0, 1, 0, 1, 0,0,0, 0,      1,0,0,1);  // lw r0 (base r7)
    tbl[6]  = mk(1,1, 0,1, 6,1, 0, 0, 0, 0,0,0, 0,      0,3,0,1);  // reads r0 and r6
    tbl[7]  = mk(1,1, 0,0, 0,0, 1, 9, 1, 0,0,0, 0,      0,0,0,1);  // lw r9
    tbl[8]  = mk(1,1, 9,1, 0,0, 1,10, 0, 0,0,1, CTL_RD, 0,0,0,1);  // load-use + redirect
    tbl[9]  = mk(1,1, 9,1, 0,0, 0, 0, 0, 0,0,0, 0,      2,0,0,1);  // reader of r9
    tbl[10] = mk(1,1, 0,0, 0,0, 1, 3, 0, 0,0,0, 0,      0,0,0,1);  // add r3
    tbl[11] = mk(1,1, 3,1, 0,0, 1, 4, 0, 1,0,0, CTL_MW, 1,0,0,1);  // wait 1
    tbl[12] = mk(1,1, 3,1, 0,0, 1, 4, 0, 1,0,0, CTL_MW, 1,0,0,2);  // wait 2
    tbl[13] = mk(1,1, 3,1, 0,0, 1, 4, 0, 1,0,0, CTL_MW, 1,0,0,3);  // wait 3
    tbl[14] = mk(1,1, 3,1, 0,0, 1, 4, 0, 1,0,0, CTL_MW, 1,0,1,4);  // wait 4: timeout
    tbl[15] = mk(1,1, 3,1, 0,0, 1, 4, 0, 1,0,0, CTL_MW, 1,0,1,5);  // wait 5
    tbl[16] = mk(1,1, 3,1, 0,0, 1, 4, 0, 1,1,0, 0,      1,0,1,6);  // dhit: advance
    tbl[17] = mk(1,1, 3,1, 4,1, 0, 0, 0, 0,0,0, 0,      2,1,1,6);  // reads r3, r4
    tbl[18] = mk(1,1, 3,1, 0,0, 0, 0, 0, 1,0,1, CTL_MW, 3,0,1,6);  // redirect under wait
    tbl[19] = mk(1,1, 3,1, 0,0, 0, 0, 0, 1,0,1, CTL_MW, 3,0,1,7);
    tbl[20] = mk(1,1, 3,1, 0,0, 0, 0, 0, 1,1,1, CTL_RD, 3,0,1,8);  // dhit: flush fires
    tbl[21] = mk(1,1, 3,1, 4,1, 1, 8, 0, 0,0,0, 0,      0,3,1,8);  // add r8
    tbl[22] = mk(0,1, 8,1, 0,0, 0, 0, 0, 1,0,1, 0,      0,0,1,8);  // start=0: quiet, hold
    tbl[23] = mk(1,1, 8,1, 0,0, 0, 0, 0, 0,0,0, 0,      1,0,1,8);  // r8 still in EX

    reset_dut("reset");
    for (int i = 0; i < NTBL; i++) begin
      apply(tbl[i], 0, $sformatf("v%0d", i));
    end

    // ALU chain without forwarding: three stall cycles, then register file.
    reset_dut("reset_b");
    apply(mk(1,1,0,0,0,0,1,3,0,0,0,0, 0,     0,0,0,0), 1, "nofwd0");
    apply(mk(1,1,3,1,0,0,1,7,0,0,0,0, CTL_LU,0,0,0,0), 1, "nofwd1");
    apply(mk(1,1,3,1,0,0,1,7,0,0,0,0, CTL_LU,0,0,0,1), 1, "nofwd2");
    apply(mk(1,1,3,1,0,0,1,7,0,0,0,0, CTL_LU,0,0,0,2), 1, "nofwd3");
    apply(mk(1,1,3,1,0,0,1,7,0,0,0,0, 0,     0,0,0,3), 1, "nofwd4");

    // Reset in the middle of a memory wait on the forwarding instance.
    reset_dut("reset_c");
    apply(mk(1,0,0,0,0,0,0,0,0,1,0,0, CTL_MW,0,0,0,0), 0, "mw1");
    apply(mk(1,0,0,0,0,0,0,0,0,1,0,0, CTL_MW,0,0,0,1), 0, "mw2");
    apply(mk(1,0,0,0,0,0,0,0,0,1,0,0, CTL_MW,0,0,0,2), 0, "mw3");
    #1;
    nRST = 1'b0;
    #1;
    z = mk(1,0,0,0,0,0,0,0,0,1,0,0, 0,0,0,0,0);
    check_outs("async_rst", 0, z);
    @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    // Fresh wait: counter restarted, so timeout only on the 4th cycle.
    w = mk(1,0,0,0,0,0,0,0,0,1,0,0, CTL_MW,0,0,0,0);
    check_outs("post_rst1", 0, w);
    @(negedge CLK);
    @(negedge CLK);
    w = mk(1,0,0,0,0,0,0,0,0,1,0,0, CTL_MW,0,0,0,2);
    check_outs("post_rst3", 0, w);
    @(negedge CLK);
    w = mk(1,0,0,0,0,0,0,0,0,1,0,0, CTL_MW,0,0,1,3);
    check_outs("post_rst4", 0, w);

    drive(mk(1,0,0,0,0,0,0,0,0,1,1,0, 0,0,0,0,0));
    @(negedge CLK);
    drive(mk(0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0));
    @(negedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Parametrised successor to the pipeline hazard unit.
- Tracks in-flight destination registers in an internal DEPTH-entry scoreboard and detects RAW hazards against the instruction in decode.
- Generates freeze, bubble and flush controls for the IF/ID and ID/EX latches, plus forwarding selects when forwarding is enabled.
- Handles multi-cycle data-memory waits, counts stall cycles, and flags memory timeouts.

Parameters:
- DEPTH, 3, scoreboard entries: entry 0 = EX, entry 1 = MEM, …, entry DEPTH-1 = WB. Legal range 2..6.
- FWD_EN, 1. 1: full forwarding, stall only on load-use. 0: stall on any RAW against any valid entry.
- MAX_WAIT, 16, memory-wait cycles before mem_timeout is set.
- CNT_W, 16, width of stall_cycles.

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- start  in  1  pipeline enable; when 0, scoreboard holds and no stalls are raised
- id_valid  in  1  decode holds a real instruction
- id_rs, id_rt  in  5 each  decode source registers
- id_use_rs, id_use_rt  in  1 each  source is actually read
- id_wen  in  1  decode instruction writes a register
- id_wsel  in  5  decode destination register
- id_is_load  in  1  decode instruction is a load
- dmem_req  in  1  MEM-stage instruction is accessing data memory
- dhit  in  1  data memory completed this cycle
- redirect  in  1  taken branch or jump resolved in EX
- freeze_if  out  1  hold PC and IF/ID
- freeze_id  out  1  hold ID/EX
- freeze_all  out  1  hold every pipeline latch (memory wait)
- flush_ifid  out  1  clear IF/ID
- bubble_idex  out  1  clear ID/EX
- fwd_rs_sel, fwd_rt_sel  out  $clog2(DEPTH+1) each  0 = register file; k = scoreboard entry k-1
- mem_timeout  out  1  sticky flag
- stall_cycles  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (nRST=0, asynchronous): all scoreboard entries invalid, state = RUN, counters = 0. All outputs 0.
- A match on entry k requires: entry valid, wsel != 0, wsel == id_rs with id_use_rs (or id_rt with id_use_rt), and id_valid.
- memwait = dmem_req & ~dhit. This is combinational: a hit in the same cycle does not stall.
- loaduse:
  - FWD_EN=1: match on entry 0 with is_load=1.
  - FWD_EN=0: match on any entry 0..DEPTH-1.
- Priority, highest first: memwait > redirect > loaduse.
- memwait: freeze_all=1; scoreboard does not shift. flush_ifid, bubble_idex, freeze_if and freeze_id are all 0.
- redirect (no memwait): flush_ifid=1, bubble_idex=1. Scoreboard shifts with an invalid entry inserted at entry 0. Any load-use stall in the same cycle is discarded.
- loaduse (no memwait, no redirect): freeze_if=1, freeze_id=1, bubble_idex=1. Scoreboard shifts with a bubble inserted at entry 0.
- Otherwise: scoreboard shifts and entry 0 loads {id_valid & id_wen, id_wsel, id_is_load}. The oldest entry drops out.
- start=0: all outputs except mem_timeout and stall_cycles are 0, and the scoreboard holds.
- Forwarding selects (FWD_EN=1 only; forced to 0 when FWD_EN=0):
  - Select the youngest (lowest k) matching non-load entry, or a load entry with k ≥ 1.
  - Output k+1; output 0 if there is no match.
- State machine:
  - RUN → WAIT on memwait.
  - WAIT → RUN on dhit.
  - wait_cnt resets to 0 when entering WAIT and increments each WAIT cycle.
  - When wait_cnt reaches MAX_WAIT, mem_timeout is set. It is sticky until reset.
- stall_cycles increments on each cycle with freeze_all or loaduse (start=1) and saturates at 2^CNT_W-1. Redirect cycles are not counted.
- Asserting nRST mid-wait returns immediately to RUN with the scoreboard cleared.

Test Plan:
- Load-use: lw to r5, then add reading r5, FWD_EN=1 → one cycle with freeze_if=freeze_id=bubble_idex=1; the following cycle has fwd_rs_sel=2; stall_cycles=1.
- ALU chain: add to r3, then sub reading r3 → no stall; fwd_rs_sel=1. Same sequence with FWD_EN=0, DEPTH=3 → 3 stall cycles, then fwd=0.
- r0 destination: lw to r0, then a reader of r0 → no stall, fwd=0.
- Memory wait: dmem_req=1 with dhit low for 5 cycles → freeze_all=1 for exactly 5 cycles; scoreboard unchanged; stall_cycles=5. MAX_WAIT=4 → mem_timeout=1 from the 4th wait cycle and stays set.
- Simultaneous events: redirect and loaduse in the same cycle → only flush_ifid=bubble_idex=1, freeze_if=0. Redirect during memwait → freeze_all only, then the flush fires on the cycle dhit arrives and the pipe advances.
- Reset mid-WAIT: nRST low at wait cycle 3 → all outputs 0 asynchronously, and stall_cycles=0.
